// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared constants for the operand-issue stage: datapath width,
//            4-bit ALU select encodings, alu_op class encodings, and the
//            ALU select decode function used at the stage input.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // ALU select encodings seen on alu_sel
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SEQ = 4'b1111;

  // alu_op instruction classes from decode
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_CUSTOM = 2'b11;

  // Resolve the ALU select from the decode fields. Any encoding that is not
  // explicitly listed falls back to ADD.
  function automatic logic [3:0] alu_sel_decode(
    input logic [1:0] alu_op,
    input logic [2:0] funct3,
    input logic       funct7b5,
    input logic       is_rtype
  );
    logic [3:0] sel;
    sel = ALU_ADD;
    case (alu_op)
      ALUOP_MEM:    sel = ALU_ADD;
      ALUOP_BRANCH: sel = ALU_SUB;
      ALUOP_ARITH: begin
        case (funct3)
          3'b000:  sel = (is_rtype & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  sel = ALU_AND;
          3'b110:  sel = ALU_OR;
          3'b010:  sel = ALU_SLT;
          default: sel = ALU_ADD;
        endcase
      end
      ALUOP_CUSTOM: begin
        case (funct3)
          3'b000:  sel = ALU_SEQ;
          3'b001:  sel = ALU_NOR;
          default: sel = ALU_ADD;
        endcase
      end
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Purpose  : Operand forwarding select for one source register. EX/MEM wins
//            over MEM/WB; register x0 is never forwarded.
// Ports    : rs_addr      - source register index being resolved
//            rf_data      - value used when neither source matches
//            ex_mem_*     - forwarding source 1 (higher priority)
//            mem_wb_*     - forwarding source 2
//            fwd_data     - resolved operand
// Revision : 1.0 - initial release
// ============================================================================
module fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_mem_wen,
  input  logic [4:0]      ex_mem_rd,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic            mem_wb_wen,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic [XLEN-1:0] fwd_data
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_wen & (ex_mem_rd != 5'd0) & (ex_mem_rd == rs_addr);
  assign mem_wb_hit = mem_wb_wen & (mem_wb_rd != 5'd0) & (mem_wb_rd == rs_addr);

  always_comb begin
    fwd_data = rf_data;
    if (ex_mem_hit) begin
      fwd_data = ex_mem_data;
    end else if (mem_wb_hit) begin
      fwd_data = mem_wb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Operand-issue stage feeding the ALU. Accepts a decoded
//            instruction over valid/ready, resolves the ALU select, forwards
//            both source operands, muxes the immediate and holds the result
//            in a single-entry output register.
// Ports    : clk, rst_n      - clock / async active-low reset
//            flush           - kills held and incoming instruction
//            in_valid/ready  - upstream handshake
//            rs*/rd/imm/...  - decoded instruction fields
//            ex_mem_*, mem_wb_* - forwarding sources
//            out_valid/ready - downstream handshake
//            alu_sel, a_in, b_in - ALU inputs
//            store_data      - forwarded rs2 value
//            rd_out, reg_wen_out - writeback passthrough
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            is_rtype,
  input  logic            reg_wen,
  input  logic            ex_mem_wen,
  input  logic [4:0]      ex_mem_rd,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic            mem_wb_wen,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] a_in,
  output logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            reg_wen_out
);

  import riscv_pkg::*;

  // Held source indices and operand-B select, needed for the stall refresh
  logic [4:0]      rs1_held;
  logic [4:0]      rs2_held;
  logic            use_imm_held;

  logic            accept;
  logic [3:0]      sel_in;
  logic [XLEN-1:0] fwd_rs1_in;
  logic [XLEN-1:0] fwd_rs2_in;
  logic [XLEN-1:0] fwd_rs1_held;
  logic [XLEN-1:0] fwd_rs2_held;

  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign sel_in   = alu_sel_decode(alu_op, funct3, funct7b5, is_rtype);

  // Input-side forwarding
  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1_in (
    .rs_addr     (rs1_addr),
    .rf_data     (rs1_data),
    .ex_mem_wen  (ex_mem_wen),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_data (ex_mem_data),
    .mem_wb_wen  (mem_wb_wen),
    .mem_wb_rd   (mem_wb_rd),
    .mem_wb_data (mem_wb_data),
    .fwd_data    (fwd_rs1_in)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2_in (
    .rs_addr     (rs2_addr),
    .rf_data     (rs2_data),
    .ex_mem_wen  (ex_mem_wen),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_data (ex_mem_data),
    .mem_wb_wen  (mem_wb_wen),
    .mem_wb_rd   (mem_wb_rd),
    .mem_wb_data (mem_wb_data),
    .fwd_data    (fwd_rs2_in)
  );

  // Held-side forwarding. The fallback value is the currently held operand,
  // so a miss simply reproduces what is already stored.
  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1_held (
    .rs_addr     (rs1_held),
    .rf_data     (a_in),
    .ex_mem_wen  (ex_mem_wen),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_data (ex_mem_data),
    .mem_wb_wen  (mem_wb_wen),
    .mem_wb_rd   (mem_wb_rd),
    .mem_wb_data (mem_wb_data),
    .fwd_data    (fwd_rs1_held)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2_held (
    .rs_addr     (rs2_held),
    .rf_data     (store_data),
    .ex_mem_wen  (ex_mem_wen),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_data (ex_mem_data),
    .mem_wb_wen  (mem_wb_wen),
    .mem_wb_rd   (mem_wb_rd),
    .mem_wb_data (mem_wb_data),
    .fwd_data    (fwd_rs2_held)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      alu_sel      <= 4'd0;
      a_in         <= '0;
      b_in         <= '0;
      store_data   <= '0;
      rd_out       <= 5'd0;
      reg_wen_out  <= 1'b0;
      rs1_held     <= 5'd0;
      rs2_held     <= 5'd0;
      use_imm_held <= 1'b0;
    end else if (flush) begin
      // Data registers are left stale; only the valid bit matters.
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      alu_sel      <= sel_in;
      a_in         <= fwd_rs1_in;
      b_in         <= use_imm ? imm : fwd_rs2_in;
      store_data   <= fwd_rs2_in;
      rd_out       <= rd_addr;
      reg_wen_out  <= reg_wen;
      rs1_held     <= rs1_addr;
      rs2_held     <= rs2_addr;
      use_imm_held <= use_imm;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled: pick up results that arrived after the entry was captured.
      a_in       <= fwd_rs1_held;
      store_data <= fwd_rs2_held;
      if (!use_imm_held) begin
        b_in <= fwd_rs2_held;
      end
    end
  end

endmodule
`default_nettype wire
